// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: one full-duplex frame per start.
// Slow sclk phases and long ss_n setup/hold suit oversampled slaves.
module spi_master_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4,
    parameter int CS_IDLE    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  ss_n,
    input  logic                  miso
);

    localparam int P1 = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int P2 = (P1 > CS_HOLD) ? P1 : CS_HOLD;
    localparam int PMAX = (P2 > CS_IDLE) ? P2 : CS_IDLE;
    localparam int CNT_W = (PMAX > 2) ? $clog2(PMAX) : 1;
    localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [BIT_W-1:0]        bit_cnt, bit_d;
    logic [DATA_WIDTH-1:0]   tx_sr, tx_sr_d;
    logic [DATA_WIDTH-1:0]   rx_sr, rx_sr_d;
    logic [DATA_WIDTH-1:0]   rx_data_d;
    logic                    sclk_d, mosi_d, ss_n_d;
    logic                    busy_d, done_d;

    // Next state plus next value of every registered output.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CNT_W'(1);
        bit_d     = bit_cnt;
        tx_sr_d   = tx_sr;
        rx_sr_d   = rx_sr;
        rx_data_d = rx_data;
        sclk_d    = sclk;
        mosi_d    = mosi;
        ss_n_d    = ss_n;
        busy_d    = busy;
        done_d    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    tx_sr_d = tx_data;
                    mosi_d  = tx_data[DATA_WIDTH-1];
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt == HALF_END) begin
                    cnt_d   = '0;
                    rx_sr_d = {rx_sr[DATA_WIDTH-2:0], miso};
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt == HALF_END) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_cnt + BIT_W'(1);
                        tx_sr_d = {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        mosi_d  = tx_sr[DATA_WIDTH-2];
                        state_d = LOW;
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    cnt_d     = '0;
                    ss_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sr;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_d;
            tx_sr   <= tx_sr_d;
            rx_sr   <= rx_sr_d;
            rx_data <= rx_data_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            ss_n    <= ss_n_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: vector table, random frames,
// oversampled slave model and a CLK_DIV=6 instance.
module tb_spi_master_tx;

    localparam int DW = 32;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD = 4;
    localparam int CS_IDLE = 4;
    localparam int BUSY4 = CS_SETUP + 2 * 4 * DW + CS_HOLD + CS_IDLE;
    localparam int BUSY6 = CS_SETUP + 2 * 6 * DW + CS_HOLD + CS_IDLE;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   tx_data = '0;
    logic          busy, done, sclk, mosi, ss_n, miso;
    logic [31:0]   rx_data;

    logic          start6 = 1'b0;
    logic [31:0]   tx6 = '0;
    logic          miso6 = 1'b0;
    logic          busy6, done6, sclk6, mosi6, ss_n6;
    logic [31:0]   rx6;

    logic [1:0]    mode = 2'd0;
    logic [31:0]   slave_pre = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    spi_master_tx u_dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .tx_data(tx_data),
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data),
        .sclk   (sclk),
        .mosi   (mosi),
        .ss_n   (ss_n),
        .miso   (miso)
    );

    spi_master_tx #(.CLK_DIV(6)) u_div6 (
        .clock  (clock),
        .reset  (reset),
        .start  (start6),
        .tx_data(tx6),
        .busy   (busy6),
        .done   (done6),
        .rx_data(rx6),
        .sclk   (sclk6),
        .mosi   (mosi6),
        .ss_n   (ss_n6),
        .miso   (miso6)
    );

    // Slave: 2-flop synchroniser plus an edge-detect flop.
    logic [2:0]  sck_s = '0;
    logic [2:0]  ssn_s = '1;
    logic [2:0]  mo_s = '0;
    logic [31:0] s_sr = '0;
    logic [31:0] s_cap = '0;

    always @(posedge clock) begin
        sck_s <= {sck_s[1:0], sclk};
        ssn_s <= {ssn_s[1:0], ss_n};
        mo_s  <= {mo_s[1:0], mosi};
        if (!ssn_s[1] && ssn_s[2])
            s_sr <= slave_pre;
        else if (!sck_s[1] && sck_s[2])
            s_sr <= {s_sr[30:0], 1'b0};
        if (sck_s[1] && !sck_s[2] && !ssn_s[1])
            s_cap <= {s_cap[30:0], mo_s[1]};
    end

    always_comb begin
        miso = 1'b0;
        case (mode)
            2'd0: miso = mosi;
            2'd1: miso = s_sr[31];
            2'd2: miso = 1'b0;
            default: miso = 1'b1;
        endcase
    end

    // Monitor of the default instance.
    int busy_tot = 0, rise_tot = 0, done_tot = 0;
    int viol = 0, done_long = 0, ssh_run = 0;
    logic sclk_q = 1'b0, done_q = 1'b0, ssn_q = 1'b1, seen_fall = 1'b0;
    int gaps_q[$];
    logic [31:0] rxd_q[$];

    always @(posedge clock) begin
        if (busy === 1'b1) busy_tot <= busy_tot + 1;
        if (sclk === 1'b1 && sclk_q !== 1'b1) rise_tot <= rise_tot + 1;
        if (done === 1'b1) begin
            done_tot <= done_tot + 1;
            rxd_q.push_back(rx_data);
        end
        if (done === 1'b1 && done_q === 1'b1) done_long <= done_long + 1;
        if (sclk === 1'b1 && ss_n !== 1'b0) viol <= viol + 1;
        if (sclk6 === 1'b1 && ss_n6 !== 1'b0) viol <= viol + 1;
        if (ss_n === 1'b1) begin
            ssh_run <= ssh_run + 1;
        end else if (ss_n === 1'b0) begin
            if (ssn_q === 1'b1 && seen_fall) gaps_q.push_back(ssh_run);
            if (ssn_q === 1'b1) seen_fall <= 1'b1;
            ssh_run <= 0;
        end
        sclk_q <= sclk;
        done_q <= done;
        ssn_q  <= ss_n;
    end

    // Monitor of the CLK_DIV=6 instance: phase lengths.
    int busy6_tot = 0, rise6_tot = 0, ph_bad6 = 0, ph_chk6 = 0;
    int hi_len = 0, lo_len = 0;
    logic lo_act = 1'b0, sclk6_q = 1'b0;

    always @(posedge clock) begin
        if (busy6 === 1'b1) busy6_tot <= busy6_tot + 1;
        sclk6_q <= sclk6;
        if (sclk6 === 1'b1) begin
            hi_len <= hi_len + 1;
            if (sclk6_q !== 1'b1) begin
                rise6_tot <= rise6_tot + 1;
                if (lo_act) begin
                    ph_chk6 <= ph_chk6 + 1;
                    if (lo_len != 6) ph_bad6 <= ph_bad6 + 1;
                end
                lo_act <= 1'b0;
            end
        end else begin
            if (sclk6_q === 1'b1) begin
                ph_chk6 <= ph_chk6 + 1;
                if (hi_len != 6) ph_bad6 <= ph_bad6 + 1;
                hi_len <= 0;
                lo_act <= 1'b1;
                lo_len <= 1;
            end else if (lo_act) begin
                lo_len <= lo_len + 1;
            end
        end
        if (ss_n6 === 1'b1) lo_act <= 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rx(input logic [1:0] m,
                                             input logic [31:0] tx,
                                             input logic [31:0] pre);
        case (m)
            2'd0: return tx;
            2'd1: return pre;
            2'd2: return 32'h0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("idle_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_idle6(input int budget);
        int k = 0;
        while (busy6 !== 1'b0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("idle6_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic do_frame(input logic [1:0] m, input logic [31:0] tx,
                            input logic [31:0] pre,
                            input logic [31:0] exp_rx);
        int b0, r0, d0;
        @(negedge clock);
        mode = m;
        slave_pre = pre;
        b0 = busy_tot;
        r0 = rise_tot;
        d0 = done_tot;
        tx_data = tx;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tx_data = $urandom;
        wait_idle(2000);
        chk("rx_data", rx_data, exp_rx);
        chk("busy_len", busy_tot - b0, BUSY4);
        chk("sclk_rises", rise_tot - r0, DW);
        chk("done_pulses", done_tot - d0, 1);
        if (m == 2'd1) chk("slave_cap", s_cap, tx);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [31:0] tx;
        logic [31:0] pre;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vt[$];

    initial begin
        int b0, d0, r0, q0, g0, k;
        logic [1:0] m;
        logic [31:0] tx, pre;

        vt.push_back('{2'd0, 32'hA5A5_5A5A, 32'h0, 32'hA5A5_5A5A});
        vt.push_back('{2'd1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vt.push_back('{2'd2, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000});
        vt.push_back('{2'd3, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF});
        vt.push_back('{2'd1, 32'h8000_0001, 32'h0000_0001, 32'h0000_0001});

        repeat (3) @(negedge clock);
        chk("rst_ss_n", 32'(ss_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", rx_data, 32'd0);
        chk("rst6_ss_n", 32'(ss_n6), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        foreach (vt[i]) do_frame(vt[i].m, vt[i].tx, vt[i].pre, vt[i].exp_rx);

        for (int i = 0; i < 8; i++) begin
            m = 2'($urandom_range(0, 3));
            tx = $urandom;
            pre = $urandom;
            do_frame(m, tx, pre, model_rx(m, tx, pre));
        end

        // start during a busy frame is dropped
        mode = 2'd0;
        b0 = busy_tot;
        d0 = done_tot;
        tx_data = 32'h0F1E_2D3C;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (49) @(negedge clock);
        tx_data = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(2000);
        chk("ign_rx", rx_data, 32'h0F1E_2D3C);
        chk("ign_busy_len", busy_tot - b0, BUSY4);
        repeat (20) @(negedge clock);
        chk("ign_not_queued", 32'(busy), 32'd0);
        chk("ign_dones", done_tot - d0, 1);

        // reset in the middle of bit 10
        do_frame(2'd0, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF);
        d0 = done_tot;
        r0 = rise_tot;
        tx_data = $urandom;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (rise_tot - r0 < 11 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("bit10_timeout", 32'(k < 2000), 32'd1);
        chk("pre_rst_rx", rx_data, 32'h1357_9BDF);
        chk("pre_rst_ss_n", 32'(ss_n), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_ss_n", 32'(ss_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx", rx_data, 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        chk("abort_no_done", done_tot - d0, 0);
        chk("abort_idle", 32'(busy), 32'd0);

        // start held high: three back-to-back frames
        mode = 2'd3;
        q0 = rxd_q.size();
        g0 = gaps_q.size();
        d0 = done_tot;
        tx_data = $urandom;
        start = 1'b1;
        k = 0;
        while (done_tot - d0 < 3 && k < 3000) begin
            @(negedge clock);
            tx_data = $urandom;
            k++;
        end
        start = 1'b0;
        chk("b2b_timeout", 32'(k < 3000), 32'd1);
        wait_idle(2000);
        repeat (20) @(negedge clock);
        chk("b2b_dones", done_tot - d0, 3);
        chk("b2b_rx_count", rxd_q.size() - q0, 3);
        for (int i = q0; i < rxd_q.size(); i++)
            chk("b2b_rx", rxd_q[i], 32'hFFFF_FFFF);
        chk("b2b_gap_count", gaps_q.size() - g0, 3);
        for (int i = g0; i < gaps_q.size(); i++)
            chk("b2b_gap_ge_idle", 32'(gaps_q[i] >= CS_IDLE), 32'd1);

        // CLK_DIV=6 instance
        miso6 = 1'b1;
        tx6 = $urandom;
        start6 = 1'b1;
        @(negedge clock);
        start6 = 1'b0;
        wait_idle6(3000);
        chk("div6_rx_ones", rx6, 32'hFFFF_FFFF);
        miso6 = 1'b0;
        b0 = busy6_tot;
        r0 = rise6_tot;
        tx6 = $urandom;
        start6 = 1'b1;
        @(negedge clock);
        start6 = 1'b0;
        wait_idle6(3000);
        chk("div6_rx_zero", rx6, 32'h0);
        chk("div6_busy_len", busy6_tot - b0, BUSY6);
        chk("div6_rises", rise6_tot - r0, DW);
        chk("div6_phase_checks", ph_chk6, 2 * (2 * DW - 1));
        chk("div6_phase_bad", ph_bad6, 0);

        chk("sclk_high_ss_n_high", viol, 0);
        chk("done_long", done_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
